// File: rtl/ball_pkg.sv
// Shared types and constants for the ball slot controllers.
package ball_pkg;

    // Ball size encoding, as exchanged with the level controller.
    typedef enum logic [1:0] {
        SMALL  = 2'd0,
        MEDIUM = 2'd1,
        BIG    = 2'd2,
        HUGE   = 2'd3
    } ball_size_t;

    // Lifecycle states of one ball slot.
    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        ALIVE,
        FLASH,
        POP
    } slot_state_t;

    localparam int unsigned SCORE_W = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ball_slot_ctrl_if.sv
// Spawn interface between the level controller (master) and a ball slot (slave).
interface ball_slot_ctrl_if;
    logic       ballActive;        // toggle-style spawn request
    logic [1:0] ballInitialState;  // size requested at spawn
    logic       ballInUse;         // slot busy, returned to the level controller

    modport master (output ballActive, output ballInitialState, input ballInUse);
    modport slave  (input ballActive, input ballInitialState, output ballInUse);
endinterface

// File: rtl/ball_slot_ctrl_toggle_req.sv
// Toggle-to-pulse request detector: every edge on the input is one request.
module toggle_req_detect (
    input  logic clk,
    input  logic resetN,
    input  logic tog,
    output logic req
);
    logic req_prev;

    // Remember the last sampled level on every clock, regardless of consumer state.
    always_ff @(posedge clk) begin
        if (!resetN) req_prev <= 1'b0;
        else         req_prev <= tog;
    end

    assign req = tog ^ req_prev;
endmodule

// File: rtl/ball_slot_ctrl.sv
// Per-ball lifecycle controller: spawn, shrink on hit, hit-flash, pop cooldown.
module ball_slot_ctrl
    import ball_pkg::*;
#(
    parameter int unsigned HIT_CYCLES = 8,
    parameter int unsigned POP_CYCLES = 16,
    parameter int unsigned SCORE_BASE = 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                enable,
    input  logic                hit,
    ball_slot_ctrl_if.slave     spawn,
    output logic [1:0]          ballSize,
    output logic                ballVisible,
    output logic                spawnPulse,
    output logic                scoreValid,
    output logic [SCORE_W-1:0]  scoreAdd
);
    // At least 2 bits so counter[1] exists for the blink.
    localparam int unsigned CNT_W =
        max_u(2, $clog2(max_u(HIT_CYCLES, POP_CYCLES)));

    slot_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         size_d;
    logic               in_use_q, in_use_d;
    logic               vis_d, spawn_d, sv_d;
    logic [SCORE_W-1:0] add_d;
    logic               req;

    toggle_req_detect u_req (
        .clk    (clk),
        .resetN (resetN),
        .tog    (spawn.ballActive),
        .req    (req)
    );

    assign spawn.ballInUse = in_use_q;

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ballSize    <= '0;
            in_use_q    <= 1'b0;
            ballVisible <= 1'b0;
            spawnPulse  <= 1'b0;
            scoreValid  <= 1'b0;
            scoreAdd    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ballSize    <= size_d;
            in_use_q    <= in_use_d;
            ballVisible <= vis_d;
            spawnPulse  <= spawn_d;
            scoreValid  <= sv_d;
            scoreAdd    <= add_d;
        end
    end

    // Next-state and next-output logic; enable low overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        size_d   = ballSize;
        in_use_d = in_use_q;
        vis_d    = 1'b0;
        spawn_d  = 1'b0;
        sv_d     = 1'b0;
        add_d    = '0;

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            size_d   = '0;
            in_use_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_use_d = 1'b0;
                    if (req) begin
                        state_d  = SPAWN;
                        size_d   = spawn.ballInitialState;
                        in_use_d = 1'b1;
                        spawn_d  = 1'b1;
                        vis_d    = 1'b1;
                    end
                end
                SPAWN: begin
                    state_d = ALIVE;
                    vis_d   = 1'b1;
                end
                ALIVE: begin
                    vis_d = 1'b1;
                    if (hit) begin
                        sv_d  = 1'b1;
                        add_d = SCORE_W'(SCORE_BASE) + SCORE_W'(ballSize);
                        if (ballSize != SMALL) begin
                            state_d = FLASH;
                            size_d  = ballSize - 2'd1;
                            cnt_d   = CNT_W'(HIT_CYCLES - 1);
                            vis_d   = cnt_d[1];
                        end else begin
                            state_d = POP;
                            cnt_d   = CNT_W'(POP_CYCLES - 1);
                            vis_d   = 1'b0;
                        end
                    end
                end
                FLASH: begin
                    if (cnt_q == '0) begin
                        state_d = ALIVE;
                        vis_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        vis_d = cnt_d[1];
                    end
                end
                POP: begin
                    if (cnt_q == '0) begin
                        state_d  = IDLE;
                        in_use_d = 1'b0;
                        size_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    in_use_d = 1'b0;
                    size_d   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ball_slot_ctrl.sv
// Directed self-checking bench for ball_slot_ctrl with default parameters.
module tb_ball_slot_ctrl;
    logic       clk = 1'b0;
    logic       resetN, enable, hit;
    logic [1:0] ballSize;
    logic       ballVisible, spawnPulse, scoreValid;
    logic [3:0] scoreAdd;
    int         n_total = 0;
    int         n_bad = 0;

    // Blink pattern in FLASH for counter 7..0 (counter bit 1).
    logic [7:0] blink_exp = 8'b1100_1100;

    ball_slot_ctrl_if sif ();

    ball_slot_ctrl #(
        .HIT_CYCLES (8),
        .POP_CYCLES (16),
        .SCORE_BASE (1)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .hit         (hit),
        .spawn       (sif.slave),
        .ballSize    (ballSize),
        .ballVisible (ballVisible),
        .spawnPulse  (spawnPulse),
        .scoreValid  (scoreValid),
        .scoreAdd    (scoreAdd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int inuse, input int size,
                             input int vis, input int sp, input int sv);
        check_val({tag, ".inuse"}, int'(sif.ballInUse), inuse);
        check_val({tag, ".size"},  int'(ballSize), size);
        check_val({tag, ".vis"},   int'(ballVisible), vis);
        check_val({tag, ".spawn"}, int'(spawnPulse), sp);
        check_val({tag, ".sv"},    int'(scoreValid), sv);
    endtask

    // Walk the 7 remaining FLASH cycles after the hit edge, one ignored hit included.
    task automatic flash_walk(input string tag, input int size);
        for (int k = 1; k < 8; k++) begin
            hit = (k == 2);
            tick();
            hit = 1'b0;
            check_val({tag, ".blink"}, int'(ballVisible), int'(blink_exp[7-k]));
            check_val({tag, ".sv"}, int'(scoreValid), 0);
            check_val({tag, ".size"}, int'(ballSize), size);
        end
        tick();
        check_out({tag, ".back_alive"}, 1, size, 1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        resetN = 1'b0; enable = 1'b0; hit = 1'b0;
        sif.ballActive = 1'b0; sif.ballInitialState = 2'd0;
        tick(); tick();
        check_out("reset", 0, 0, 0, 0, 0);
        check_val("reset.add", int'(scoreAdd), 0);

        resetN = 1'b1; enable = 1'b1;
        tick();
        check_out("idle", 0, 0, 0, 0, 0);

        // Spawn a big ball.
        sif.ballActive = 1'b1; sif.ballInitialState = 2'd2;
        tick();
        check_out("spawn", 1, 2, 1, 1, 0);
        tick();
        check_out("alive", 1, 2, 1, 0, 0);

        // Toggle while busy is discarded.
        sif.ballActive = 1'b0;
        tick();
        check_out("busy_req", 1, 2, 1, 0, 0);
        tick();
        check_out("busy_req2", 1, 2, 1, 0, 0);

        // Hit big -> medium, flash.
        hit = 1'b1; tick(); hit = 1'b0;
        check_out("hit_big", 1, 1, 1, 0, 1);
        check_val("hit_big.add", int'(scoreAdd), 3);
        flash_walk("flash1", 1);

        // Hit medium -> small, flash.
        hit = 1'b1; tick(); hit = 1'b0;
        check_out("hit_med", 1, 0, 1, 0, 1);
        check_val("hit_med.add", int'(scoreAdd), 2);
        flash_walk("flash2", 0);

        // Hit small -> pop cooldown for 16 cycles.
        hit = 1'b1; tick(); hit = 1'b0;
        check_out("hit_small", 1, 0, 0, 0, 1);
        check_val("hit_small.add", int'(scoreAdd), 1);
        for (int k = 1; k < 16; k++) begin
            hit = (k == 5);
            tick();
            hit = 1'b0;
            check_out("pop", 1, 0, 0, 0, 0);
        end
        tick();
        check_out("pop_done", 0, 0, 0, 0, 0);

        // Spawn medium with simultaneous hit in IDLE; hit ignored, single spawn.
        sif.ballActive = 1'b1; sif.ballInitialState = 2'd1; hit = 1'b1;
        tick(); hit = 1'b0;
        check_out("spawn_hit", 1, 1, 1, 1, 0);
        tick();
        check_out("spawn_hit.alive", 1, 1, 1, 0, 0);
        tick();
        check_out("spawn_once", 1, 1, 1, 0, 0);

        // Enter FLASH, then drop enable with a hit.
        hit = 1'b1; tick(); hit = 1'b0;
        check_out("hit_med2", 1, 0, 1, 0, 1);
        check_val("hit_med2.add", int'(scoreAdd), 2);
        tick();
        enable = 1'b0; hit = 1'b1;
        tick(); hit = 1'b0;
        check_out("en_drop", 0, 0, 0, 0, 0);

        // Toggle while disabled only updates reqPrev.
        sif.ballActive = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check_out("dis_toggle", 0, 0, 0, 0, 0);
        tick();
        check_out("dis_toggle2", 0, 0, 0, 0, 0);

        // Spawn small; hit during SPAWN is ignored.
        sif.ballActive = 1'b1; sif.ballInitialState = 2'd0;
        tick();
        check_out("spawn_small", 1, 0, 1, 1, 0);
        hit = 1'b1; tick(); hit = 1'b0;
        check_out("spawn_ignhit", 1, 0, 1, 0, 0);

        // Pop it, then reset mid-POP with ballActive returned to 0.
        hit = 1'b1; tick(); hit = 1'b0;
        check_out("pop2", 1, 0, 0, 0, 1);
        check_val("pop2.add", int'(scoreAdd), 1);
        tick(); tick();
        sif.ballActive = 1'b0;
        resetN = 1'b0;
        tick();
        check_out("reset_pop", 0, 0, 0, 0, 0);
        resetN = 1'b1;
        tick();
        check_out("post_reset", 0, 0, 0, 0, 0);
        tick();
        check_out("post_reset2", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ball_slot_ctrl.md
Name: ball_slot_ctrl

Overview:
Per-ball lifecycle controller; one instance per ball slot (ball1..ball3). It is the receiving end of the level controller's spawn interface. It consumes the toggled activation request and the initial size, and reports the slot busy back through ballInUse. It then tracks the ball through spawn, hits (shrinking), hit-flash and pop cooldown, and emits score awards and a spawn pulse for the ball motion block.

Parameters:
HIT_CYCLES, 8, hit-flash duration in clk cycles (>=2)
POP_CYCLES, 16, post-pop cooldown in clk cycles during which the slot stays busy (>=1)
SCORE_BASE, 1, base points per hit; award = SCORE_BASE + size before hit

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
enable  in  1  play mode; low forces slot idle
ballActive  in  1  spawn request; every toggle (0->1 or 1->0) is one request
ballInitialState  in  2  requested size at spawn: 0 small, 1 medium, 2 big, 3 huge
hit  in  1  single-cycle collision pulse (rope/shot hit this ball)
ballInUse  out  1  slot busy, returned to level controller
ballSize  out  2  current size
ballVisible  out  1  draw enable for ball renderer
spawnPulse  out  1  one-cycle strobe: ball motion block reloads start position/velocity
scoreValid  out  1  one-cycle strobe: scoreAdd is valid
scoreAdd  out  4  points to add to score

Behaviour:
- Reset only on rising clk with resetN=0, synchronous. Reset values: state IDLE, reqPrev 0, counter 0, all outputs 0.
- All outputs are registered and derived from next-state logic, so they align with the state they describe.
- Request detect: req = ballActive XOR reqPrev. reqPrev <= ballActive on every clk, in every state. Requests arriving outside IDLE are discarded, not queued.
- States: IDLE, SPAWN, ALIVE, FLASH, POP.
- IDLE: ballInUse=0, ballVisible=0. If enable && req: go to SPAWN, and set ballSize <= ballInitialState, ballInUse <= 1, spawnPulse <= 1.
- SPAWN: lasts exactly 1 cycle; ballVisible=1; hit is ignored. Then go to ALIVE with spawnPulse <= 0.
- ALIVE: ballVisible=1. On hit:
  - scoreValid <= 1 and scoreAdd <= SCORE_BASE + ballSize (4-bit, no overflow for defaults).
  - If ballSize > 0: ballSize <= ballSize-1, go to FLASH with counter <= HIT_CYCLES-1.
  - If ballSize == 0: go to POP with counter <= POP_CYCLES-1 and ballVisible <= 0.
- FLASH: ballVisible = counter[1] (blink); hit is ignored; counter decrements each cycle. At counter==0, go to ALIVE.
- POP: ballVisible=0, ballInUse stays 1; counter decrements. At counter==0, go to IDLE and set ballInUse <= 0, ballSize <= 0.
- scoreValid is high for exactly one cycle per accepted hit; it is 0 otherwise.
- enable=0 in any state: go to IDLE next cycle; ballInUse, ballVisible, spawnPulse, scoreValid <= 0; ballSize <= 0; no score is awarded. This rule has priority over hit and req.
- Simultaneous enable&&req in IDLE together with hit: spawn proceeds and hit is ignored.
- A toggle on ballActive while enable=0 updates reqPrev only and produces no spawn later.
- Latency from request to ballInUse: ballActive toggles before edge N; ballInUse=1 and spawnPulse=1 after edge N; ALIVE after edge N+1.
- Latency from hit to score: hit sampled at edge N; scoreValid=1 after edge N.
- Full lifecycle of a huge ball = 4 hits; it never returns to IDLE without enable dropping or a size-0 pop.

Decomposition:
- Shared package ball_pkg: typedef ball_size_t enum {SMALL=0, MEDIUM=1, BIG=2, HUGE=3} (2 bits); typedef slot_state_t enum {IDLE, SPAWN, ALIVE, FLASH, POP}; constant SCORE_W=4.
- Counter width is $clog2(max(HIT_CYCLES, POP_CYCLES)).
- One natural sub-module: toggle_req_detect. It holds the reqPrev register and the XOR, and is reusable for every toggle-style request between the level controller and the slots.

Test Plan:
- Reset then spawn: resetN=0 for 2 clk; outputs all 0. Toggle ballActive 0->1 with ballInitialState=2 and enable=1 -> next edge: ballInUse=1, spawnPulse=1, ballSize=2; following edge: ALIVE, spawnPulse=0, ballVisible=1.
- Full pop of medium ball (size 1): hit -> scoreValid=1, scoreAdd=2, ballSize=0, ballVisible blinks for 8 cycles. Then hit -> scoreAdd=1, ballVisible=0, ballInUse held 1 for 16 cycles, then ballInUse=0 in IDLE.
- Requests while busy: toggle ballActive 1->0 during ALIVE -> no re-spawn, size unchanged. A later toggle in IDLE spawns exactly once.
- Hits ignored outside ALIVE: hit during SPAWN, FLASH and POP -> scoreValid stays 0 and ballSize is unchanged.
- Enable drop mid-FLASH with simultaneous hit: next edge -> IDLE, ballInUse=0, ballSize=0, scoreValid=0.
- Reset mid-POP (resetN=0 on one edge) -> all outputs 0. A toggle of ballActive held from before reset does not spawn, because reqPrev resets to 0 and ballActive=0.
